// File: rtl/axis_burst_reader.sv
`default_nettype none
// ============================================================================
// Module   : axis_burst_reader
// Brief    : Drains fixed-length bursts from an AXI4-Stream FIFO only once the
//            whole burst is buffered; marks the final beat with tlast.
// Revision : 1.0 - initial release
// ============================================================================
module axis_burst_reader #(
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int CNTR_WIDTH       = 10
) (
    input  logic                        aclk,
    input  logic                        areset,
    input  logic [CNTR_WIDTH-1:0]       cfg_length,
    input  logic [CNTR_WIDTH-1:0]       fifo_count,
    input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic                        s_axis_tvalid,
    output logic                        s_axis_tready,
    output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic                        m_axis_tlast,
    output logic                        busy,
    output logic [31:0]                 sts_bursts
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BURST = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;

    localparam logic [CNTR_WIDTH-1:0] c_one = {{(CNTR_WIDTH-1){1'b0}}, 1'b1};

    logic [1:0]                  r_state;
    logic [CNTR_WIDTH-1:0]       r_len;
    logic [CNTR_WIDTH-1:0]       r_beat_cnt;
    logic [AXIS_TDATA_WIDTH-1:0] r_tdata;
    logic                        r_tvalid;
    logic                        r_tlast;
    logic [31:0]                 r_bursts;

    logic w_in_hs;
    logic w_out_hs;
    logic w_last_beat;
    logic w_start;

    // Pop only when the output slice is empty or draining this cycle.
    assign s_axis_tready = (r_state == S_BURST) & (~r_tvalid | m_axis_tready);
    assign w_in_hs       = s_axis_tready & s_axis_tvalid;
    assign w_out_hs      = r_tvalid & m_axis_tready;
    assign w_last_beat   = (r_beat_cnt == (r_len - c_one));
    assign w_start       = (cfg_length != '0) && (fifo_count >= cfg_length);

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state    <= S_IDLE;
            r_len      <= '0;
            r_beat_cnt <= '0;
            r_tdata    <= '0;
            r_tvalid   <= 1'b0;
            r_tlast    <= 1'b0;
            r_bursts   <= '0;
        end else begin
            if (w_in_hs) begin
                r_tdata  <= s_axis_tdata;
                r_tvalid <= 1'b1;
                r_tlast  <= w_last_beat;
            end else if (w_out_hs) begin
                r_tvalid <= 1'b0;
                r_tlast  <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_len      <= cfg_length;
                        r_beat_cnt <= '0;
                        r_state    <= S_BURST;
                    end
                end
                S_BURST: begin
                    if (w_in_hs) begin
                        r_beat_cnt <= r_beat_cnt + c_one;
                        if (w_last_beat) begin
                            r_bursts <= r_bursts + 32'd1;
                            r_state  <= S_GAP;
                        end
                    end
                end
                // One dead cycle so fifo_count reflects the final pop.
                S_GAP:   r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign m_axis_tdata  = r_tdata;
    assign m_axis_tvalid = r_tvalid;
    assign m_axis_tlast  = r_tlast;
    assign busy          = (r_state == S_BURST) | (r_state == S_GAP);
    assign sts_bursts    = r_bursts;

endmodule
`default_nettype wire
